// File: rtl/cpu_icache_pkg.sv
// Shared types and FSM encodings for the direct-mapped instruction cache.
package cpu_icache_pkg;
  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
  typedef logic [7:0]  byte_t;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_REFILL = 1'b1;
endpackage

// File: rtl/cpu_icache_array.sv
// Valid/tag/data storage: two combinational read ports, one write port, bulk invalidate.
module cpu_icache_array
  import cpu_icache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int TAG_W = 24,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             we_i,
  input  logic             wvalid_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [TAG_W-1:0] wtag_i,
  input  word_t            wdata_i,
  input  logic [IDX_W-1:0] ridx_a_i,
  output logic             rvalid_a_o,
  output logic [TAG_W-1:0] rtag_a_o,
  output word_t            rdata_a_o,
  input  logic [IDX_W-1:0] ridx_b_i,
  output logic             rvalid_b_o,
  output logic [TAG_W-1:0] rtag_b_o,
  output word_t            rdata_b_o
);
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  word_t            data_q [LINES];

  // A write in the same cycle as a bulk invalidate carries wvalid_i=0, so flush wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      if (flush_i) valid_q <= '0;
      if (we_i) valid_q[widx_i] <= wvalid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign rvalid_a_o = valid_q[ridx_a_i];
  assign rtag_a_o   = tag_q[ridx_a_i];
  assign rdata_a_o  = data_q[ridx_a_i];
  assign rvalid_b_o = valid_q[ridx_b_i];
  assign rtag_b_o   = tag_q[ridx_b_i];
  assign rdata_b_o  = data_q[ridx_b_i];
endmodule

// File: rtl/cpu_icache.sv
// Direct-mapped one-word-per-line I-cache with a refilling port x and a lookup-only port y.
module cpu_icache
  import cpu_icache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int TAG_W = 32 - 2 - $clog2(LINES)
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rdy,
  input  logic  en_rx,
  input  addr_t pcx,
  input  logic  en_ry,
  input  addr_t pcy,
  input  logic  flush,
  output logic  hitx,
  output logic  hity,
  output word_t instx,
  output word_t insty,
  output logic  mem_req,
  output addr_t mem_addr,
  input  logic  mem_valid,
  input  byte_t mem_byte
);
  localparam int IDX_W = $clog2(LINES);

  logic [0:0]       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  addr_t            addr_q, addr_d;
  logic             flushed_q, flushed_d;
  logic [23:0]      buf_q, buf_d;
  logic             we, wvalid;
  logic             vx, vy;
  logic [TAG_W-1:0] tx, ty;

  cpu_icache_array #(.LINES(LINES), .TAG_W(TAG_W)) u_array (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush && rdy),
    .we_i       (we),
    .wvalid_i   (wvalid),
    .widx_i     (addr_q[2 +: IDX_W]),
    .wtag_i     (addr_q[2+IDX_W +: TAG_W]),
    .wdata_i    ({buf_q, mem_byte}),
    .ridx_a_i   (pcx[2 +: IDX_W]),
    .rvalid_a_o (vx),
    .rtag_a_o   (tx),
    .rdata_a_o  (instx),
    .ridx_b_i   (pcy[2 +: IDX_W]),
    .rvalid_b_o (vy),
    .rtag_b_o   (ty),
    .rdata_b_o  (insty)
  );

  assign hitx     = en_rx && vx && (tx == pcx[2+IDX_W +: TAG_W]);
  assign hity     = en_ry && vy && (ty == pcy[2+IDX_W +: TAG_W]);
  assign mem_req  = (state_q == ST_REFILL);
  assign mem_addr = addr_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pcx[1:0], pcy[1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    flushed_d = flushed_q;
    buf_d     = buf_q;
    we        = 1'b0;
    wvalid    = 1'b0;
    if (rdy) begin
      case (state_q)
        ST_IDLE: begin
          if (en_rx && !hitx && !flush) begin
            state_d   = ST_REFILL;
            addr_d    = pcx;
            cnt_d     = '0;
            flushed_d = 1'b0;
          end
        end
        default: begin
          // A flush seen at any point of the refill keeps the finished line invalid.
          if (flush) flushed_d = 1'b1;
          if (mem_valid) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
              2'd0: buf_d[23:16] = mem_byte;
              2'd1: buf_d[15:8]  = mem_byte;
              2'd2: buf_d[7:0]   = mem_byte;
              default: begin
                we      = 1'b1;
                wvalid  = !(flushed_q || flush);
                state_d = ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      flushed_q <= flushed_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end
endmodule

// File: doc/cpu_icache.md
CPU_ICACHE -- requirements
Module: cpu_icache

Interface
REQ-001 Parameter LINES, default 64, number of direct-mapped one-word lines (power of two, 4..1024).
REQ-002 Parameter TAG_W, default 32-2-log2(LINES), tag width taken from pc[31 : 2+log2(LINES)].
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-low: state cleared on a posedge where rst==0.
REQ-005 rdy  in  1  global ready; when 0, all state frozen.
REQ-006 en_rx  in  1  port-x lookup/refill enable.
REQ-007 pcx  in  32  port-x fetch address, word aligned.
REQ-008 en_ry  in  1  port-y lookup enable (lookup only, never refills).
REQ-009 pcy  in  32  port-y fetch address.
REQ-010 flush  in  1  invalidate all lines (fence.i).
REQ-011 hitx / hity  out  1  lookup hit for port x / y.
REQ-012 instx / insty  out  32  instruction word, byte mem[pc+0] in [31:24] through mem[pc+3] in [7:0].
REQ-013 mem_req  out  1  refill request, held high until the 4th byte is accepted.
REQ-014 mem_addr  out  32  word-aligned refill address, stable while mem_req==1.
REQ-015 mem_valid  in  1  one refill byte present this cycle.
REQ-016 mem_byte  in  8  refill byte, delivered in order addr+0..addr+3.

Function
REQ-017 Lookup is combinational: hitx = en_rx & valid[idx(pcx)] & (tag[idx(pcx)]==tag(pcx)); hity likewise with en_ry/pcy.
REQ-018 instx/insty are driven from the data array at idx regardless of hit; consumers use them only when hit==1.
REQ-019 FSM states IDLE, REFILL.
REQ-020 IDLE -> REFILL at a posedge where en_rx==1, hitx==0, flush==0, rdy==1; pcx latched into mem_addr, byte counter cleared, mem_req=1 from the next cycle.
REQ-021 In REFILL each posedge with mem_valid==1 and rdy==1 stores mem_byte into the byte lane selected by the counter, then increments the counter.
REQ-022 On the 4th accepted byte: line written, valid set, tag written, mem_req deasserted, state -> IDLE; hitx==1 combinationally in the next cycle if pcx still equals mem_addr.
REQ-023 Miss-to-hit latency: 1 cycle + 4 byte-beats + 0 cycles; each beat is any cycle with mem_valid==1.
REQ-024 pcx changes during REFILL do not abort the refill; the latched line completes, then a fresh lookup occurs in IDLE.
REQ-025 mem_valid while in IDLE is ignored.
REQ-026 flush in IDLE clears all valid bits at the posedge; hitx/hity are 0 from the next cycle.
REQ-027 flush during REFILL clears all valid bits, lets the remaining bytes drain with mem_req held, and suppresses the final valid-bit set (line data may be written, valid stays 0).
REQ-028 flush coinciding with the 4th byte: flush wins; the line is not valid afterwards.
REQ-029 Port y never starts a refill; a hity miss is only reported.
REQ-030 A port-x and port-y hit on the same index in the same cycle both return that line.

Reset
REQ-031 On reset: state=IDLE, all valid bits=0, counter=0, mem_req=0, mem_addr=0, hitx=hity=0; data/tag arrays need not be cleared.
REQ-032 Reset mid-REFILL aborts immediately; mem_req is 0 the following cycle and no line becomes valid.
REQ-033 Reset has priority over rdy==0 and flush.

Structure
REQ-034 Shared package/defines: word_t (32), addr_t (32), byte_t (8), and the icache state encodings.
REQ-035 One sub-module, cpu_icache_array: valid/tag/data storage with two combinational read ports and one write port.

Verification
REQ-036 Cold miss: pcx=0x100, en_rx=1; memory returns 0x13,0x00,0x00,0x00 -> mem_req=1 with mem_addr=0x100, then hitx=1, instx=0x13000000 in the next cycle.
REQ-037 Back-pressure: mem_valid gaps of 3 cycles between bytes and a 2-cycle rdy=0 -> counter and mem_req hold, same final line, no extra or lost byte.
REQ-038 Conflict: fill 0x100, then pcx=0x200 (same index, LINES=64) -> miss, refill, 0x100 subsequently misses.
REQ-039 Flush during 3rd byte of a refill to 0x40 -> mem_req held through byte 4, then hitx=0 at 0x40; a fresh refill starts.
REQ-040 Reset (rst=0) after 2 bytes -> mem_req=0 next cycle, all lookups miss after release.
REQ-041 Dual port: lines 0x0 and 0x4 filled, pcx=0x0, pcy=0x4, en_ry=1 -> hitx=hity=1 with correct words; pcy=0x8 unfilled -> hity=0, no refill started.
